button_event_arbiter: RTL and testbench

- Collects debounced button levels from NBTN per-button debounce instances.
- Converts edges and hold durations into discrete PRESS / RELEASE / LONG events.
- Queues one pending event per button.
- Shares a single event output channel between buttons via a round-robin arbiter with a valid/ready handshake.
- Sits between the debounce bank and the FSM/CPU logic that consumes user input.

---
 rtl/button_event_arbiter_pkg.sv | 27 ++
 rtl/button_event_arbiter_rr.sv | 36 +++
 rtl/button_event_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_button_event_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_event_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_evt_pkg
// Description : Shared types and defaults for the button event arbiter:
//               event-kind encoding, default hold length and timestamp
//               width, and the round-robin pointer increment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package btn_evt_pkg;

  typedef enum logic [1:0] {
    EVT_NONE    = 2'b00,
    EVT_PRESS   = 2'b01,
    EVT_RELEASE = 2'b10,
    EVT_LONG    = 2'b11
  } evt_kind_t;

  localparam int c_LONG_CYCLES_DEF = 50000;
  localparam int c_TS_W_DEF        = 16;

  // Pointer increment that wraps at n, correct for non-power-of-two n.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_event_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. Searches req starting at
//               ptr and returns the first requester found. The pointer
//               register lives in the parent.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx
);

  // Scan offsets high to low so the requester closest to ptr is kept last.
  always_comb begin
    int j;
    grant_valid = 1'b0;
    grant_idx   = '0;
    j           = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/button_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : button_event_arbiter
// Description : Turns debounced button levels into PRESS / RELEASE / LONG
//               events, keeps one pending event per button and shares a
//               single valid/ready output channel via round-robin.
//               Optional macro BTN_EVT_TIMESTAMP_EN adds a free-running
//               timestamp captured per event and presented on event_ts.
// Revision    : 1.0 - initial release
// ============================================================================
module button_event_arbiter
  import btn_evt_pkg::*;
#(
  parameter int NBTN        = 4,
  parameter int LONG_W      = 16,
  parameter int LONG_CYCLES = c_LONG_CYCLES_DEF
`ifdef BTN_EVT_TIMESTAMP_EN
  ,
  parameter int TS_W        = c_TS_W_DEF
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NBTN-1:0]         btn_level,
  input  logic                    event_ready,
  output logic                    event_valid,
  output logic [$clog2(NBTN)-1:0] event_id,
  output logic [1:0]              event_kind,
`ifdef BTN_EVT_TIMESTAMP_EN
  output logic [TS_W-1:0]         event_ts,
`endif
  output logic [NBTN-1:0]         ovf_flags,
  input  logic                    ovf_clear
);

  localparam int              IW          = $clog2(NBTN);
  localparam logic [LONG_W-1:0] c_LONG_LAST = LONG_W'(LONG_CYCLES - 1);

  logic [NBTN-1:0]   prev_q;
  logic [NBTN-1:0]   long_done_q, long_done_d;
  logic [LONG_W-1:0] hold_q [NBTN];
  logic [LONG_W-1:0] hold_d [NBTN];
  logic [NBTN-1:0]   pend_v_q, pend_v_d;
  evt_kind_t         pend_k_q [NBTN];
  evt_kind_t         pend_k_d [NBTN];
  logic [NBTN-1:0]   ovf_q, ovf_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              out_v_q, out_v_d;
  logic [IW-1:0]     out_id_q, out_id_d;
  evt_kind_t         out_k_q, out_k_d;

  logic [NBTN-1:0]   w_load_slot;
  logic              w_out_load;
  logic              w_grant_valid;
  logic [IW-1:0]     w_grant_idx;

  rr_arbiter #(.N(NBTN)) u_rr (
    .req         (pend_v_q),
    .ptr         (rr_ptr_q),
    .grant_valid (w_grant_valid),
    .grant_idx   (w_grant_idx)
  );

  assign w_out_load = !out_v_q || event_ready;

  // Per-button edge detection, hold counting and pending-slot update.
  always_comb begin
    logic      rise, fall, lng, take;
    evt_kind_t kind;
    ovf_d = ovf_clear ? '0 : ovf_q;
    for (int i = 0; i < NBTN; i++) begin
      rise           = btn_level[i] & ~prev_q[i];
      fall           = ~btn_level[i] & prev_q[i];
      lng            = 1'b0;
      hold_d[i]      = hold_q[i];
      long_done_d[i] = long_done_q[i];
      if (rise) begin
        hold_d[i]      = '0;
        long_done_d[i] = 1'b0;
      end else if (fall) begin
        hold_d[i] = '0;
      end else if (btn_level[i] && !long_done_q[i]) begin
        if (hold_q[i] == c_LONG_LAST) begin
          lng            = 1'b1;
          long_done_d[i] = 1'b1;
        end else begin
          hold_d[i] = hold_q[i] + 1'b1;
        end
      end
      kind = rise ? EVT_PRESS : (fall ? EVT_RELEASE : EVT_LONG);
      take = w_out_load && w_grant_valid && (w_grant_idx == IW'(i));
      w_load_slot[i] = (rise || fall || lng) && (!pend_v_q[i] || take);
      pend_v_d[i]    = pend_v_q[i];
      pend_k_d[i]    = pend_k_q[i];
      if (w_load_slot[i]) begin
        pend_v_d[i] = 1'b1;
        pend_k_d[i] = kind;
      end else if (take) begin
        pend_v_d[i] = 1'b0;
      end
      // A set in the same cycle as ovf_clear takes precedence.
      if ((rise || fall || lng) && pend_v_q[i] && !take) ovf_d[i] = 1'b1;
    end
  end

  // Output register, loaded only when empty or being consumed.
  always_comb begin
    out_v_d  = out_v_q;
    out_id_d = out_id_q;
    out_k_d  = out_k_q;
    rr_ptr_d = rr_ptr_q;
    if (w_out_load) begin
      if (w_grant_valid) begin
        out_v_d  = 1'b1;
        out_id_d = w_grant_idx;
        out_k_d  = pend_k_q[w_grant_idx];
        rr_ptr_d = IW'(wrap_inc(int'(w_grant_idx), NBTN));
      end else begin
        out_v_d = 1'b0;
      end
    end
  end

  // State registers; reset discards all pending and in-flight events.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q      <= '0;
      long_done_q <= '0;
      pend_v_q    <= '0;
      ovf_q       <= '0;
      rr_ptr_q    <= '0;
      out_v_q     <= 1'b0;
      out_id_q    <= '0;
      out_k_q     <= EVT_NONE;
      for (int i = 0; i < NBTN; i++) begin
        hold_q[i]   <= '0;
        pend_k_q[i] <= EVT_NONE;
      end
    end else begin
      prev_q      <= btn_level;
      long_done_q <= long_done_d;
      pend_v_q    <= pend_v_d;
      ovf_q       <= ovf_d;
      rr_ptr_q    <= rr_ptr_d;
      out_v_q     <= out_v_d;
      out_id_q    <= out_id_d;
      out_k_q     <= out_k_d;
      for (int i = 0; i < NBTN; i++) begin
        hold_q[i]   <= hold_d[i];
        pend_k_q[i] <= pend_k_d[i];
      end
    end
  end

  assign event_valid = out_v_q;
  assign event_id    = out_id_q;
  assign event_kind  = out_k_q;
  assign ovf_flags   = ovf_q;

`ifdef BTN_EVT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt_q;
  logic [TS_W-1:0] pend_ts_q [NBTN];
  logic [TS_W-1:0] out_ts_q;

  // Free-running timestamp; slots capture it in the detection cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_cnt_q <= '0;
      out_ts_q <= '0;
      for (int i = 0; i < NBTN; i++) pend_ts_q[i] <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 1'b1;
      if (w_out_load && w_grant_valid) out_ts_q <= pend_ts_q[w_grant_idx];
      for (int i = 0; i < NBTN; i++) begin
        if (w_load_slot[i]) pend_ts_q[i] <= ts_cnt_q;
      end
    end
  end

  assign event_ts = out_ts_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_button_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_event_arbiter
// Description : Directed-vector scoreboard bench for button_event_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_event_arbiter;
  import btn_evt_pkg::*;

  localparam int NBTN        = 4;
  localparam int LONG_W      = 16;
  localparam int LONG_CYCLES = 20;
`ifdef BTN_EVT_TIMESTAMP_EN
  localparam int TS_W = 8;
  logic [TS_W-1:0] event_ts;
`endif

  logic            clk         = 1'b0;
  logic            reset       = 1'b1;
  logic [NBTN-1:0] btn_level   = '0;
  logic            event_ready = 1'b0;
  logic            ovf_clear   = 1'b0;
  logic            event_valid;
  logic [1:0]      event_id;
  logic [1:0]      event_kind;
  logic [NBTN-1:0] ovf_flags;

  typedef struct packed {
    logic [1:0] id;
    logic [1:0] kind;
  } exp_t;

  exp_t exp_q[$];
  int   cyc_q[$];
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t mon_e;

  button_event_arbiter #(
    .NBTN        (NBTN),
    .LONG_W      (LONG_W),
    .LONG_CYCLES (LONG_CYCLES)
`ifdef BTN_EVT_TIMESTAMP_EN
    ,
    .TS_W        (TS_W)
`endif
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_level   (btn_level),
    .event_ready (event_ready),
    .event_valid (event_valid),
    .event_id    (event_id),
    .event_kind  (event_kind),
`ifdef BTN_EVT_TIMESTAMP_EN
    .event_ts    (event_ts),
`endif
    .ovf_flags   (ovf_flags),
    .ovf_clear   (ovf_clear)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [1:0] kind);
    exp_t e;
    e.id   = id;
    e.kind = kind;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted handshake is matched against the scoreboard.
  always @(negedge clk) begin
    if (!reset && event_valid && event_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_event: got id %0d kind %0d expected none", event_id, event_kind);
      end else begin
        mon_e = exp_q.pop_front();
        chk("evt_id", int'(event_id), int'(mon_e.id));
        chk("evt_kind", int'(event_kind), int'(mon_e.kind));
        cyc_q.push_back(cyc);
      end
    end
  end

  initial begin
    // Reset state
    tick(3);
    chk("rst_valid", int'(event_valid), 0);
    chk("rst_id", int'(event_id), 0);
    chk("rst_kind", int'(event_kind), 0);
    chk("rst_ovf", int'(ovf_flags), 0);
    reset = 1'b0;
    event_ready = 1'b1;
    tick(10);

    // Single press: two-cycle latency, one-cycle valid
    btn_level[2] = 1'b1;
    push(2'd2, EVT_PRESS);
    tick(1);
    chk("t1_lat", int'(event_valid), 0);
    tick(1);
    chk("t1_valid", int'(event_valid), 1);
    chk("t1_id", int'(event_id), 2);
    chk("t1_kind", int'(event_kind), 1);
    tick(1);
    chk("t1_one_cycle", int'(event_valid), 0);
    btn_level[2] = 1'b0;
    push(2'd2, EVT_RELEASE);
    tick(4);

    // Simultaneous presses from pointer 0, then releases check the wrap
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(2);
    btn_level = 4'b1011;
    push(2'd0, EVT_PRESS);
    push(2'd1, EVT_PRESS);
    push(2'd3, EVT_PRESS);
    tick(2);
    chk("t2_v0", int'(event_valid), 1);
    chk("t2_id0", int'(event_id), 0);
    tick(1);
    chk("t2_v1", int'(event_valid), 1);
    chk("t2_id1", int'(event_id), 1);
    tick(1);
    chk("t2_v3", int'(event_valid), 1);
    chk("t2_id3", int'(event_id), 3);
    tick(1);
    chk("t2_idle", int'(event_valid), 0);
    btn_level = 4'b0000;
    push(2'd0, EVT_RELEASE);
    push(2'd1, EVT_RELEASE);
    push(2'd3, EVT_RELEASE);
    tick(6);

    // Long hold: PRESS, one LONG after LONG_CYCLES, RELEASE
    cyc_q.delete();
    btn_level[1] = 1'b1;
    push(2'd1, EVT_PRESS);
    push(2'd1, EVT_LONG);
    tick(LONG_CYCLES + 100);
    btn_level[1] = 1'b0;
    push(2'd1, EVT_RELEASE);
    tick(5);
    chk("t3_events", cyc_q.size(), 3);
    if (cyc_q.size() == 3) chk("t3_long_delay", cyc_q[1] - cyc_q[0], LONG_CYCLES);

    // Back-pressure: stable output, slot fill, drop and overflow flag
    event_ready = 1'b0;
    btn_level[0] = 1'b1;
    push(2'd0, EVT_PRESS);
    tick(2);
    chk("t4_valid", int'(event_valid), 1);
    chk("t4_kind", int'(event_kind), 1);
    tick(1);
    btn_level[0] = 1'b0;
    push(2'd0, EVT_RELEASE);
    tick(2);
    btn_level[0] = 1'b1;
    tick(1);
    chk("t4_ovf", int'(ovf_flags), 1);
    chk("t4_hold_id", int'(event_id), 0);
    chk("t4_hold_kind", int'(event_kind), 1);
    tick(1);
    ovf_clear = 1'b1;
    tick(1);
    ovf_clear = 1'b0;
    chk("t4_ovf_clr", int'(ovf_flags), 0);
    event_ready = 1'b1;
    tick(4);
    btn_level[0] = 1'b0;
    push(2'd0, EVT_RELEASE);
    tick(5);

    // Overflow coinciding with ovf_clear: the set wins
    event_ready = 1'b0;
    btn_level[3] = 1'b1;
    push(2'd3, EVT_PRESS);
    tick(3);
    btn_level[3] = 1'b0;
    push(2'd3, EVT_RELEASE);
    tick(2);
    btn_level[3] = 1'b1;
    ovf_clear = 1'b1;
    tick(1);
    ovf_clear = 1'b0;
    chk("t5_ovf_set_wins", int'(ovf_flags), 8);
    event_ready = 1'b1;
    tick(3);
    btn_level[3] = 1'b0;
    push(2'd3, EVT_RELEASE);
    tick(5);

    // Asynchronous reset while output valid and a slot pending
    event_ready = 1'b0;
    btn_level = 4'b0011;
    tick(2);
    chk("t6_pre_valid", int'(event_valid), 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_valid", int'(event_valid), 0);
    chk("t6_async_id", int'(event_id), 0);
    chk("t6_async_kind", int'(event_kind), 0);
    chk("t6_async_ovf", int'(ovf_flags), 8 - 8);
    btn_level = 4'b0000;
    tick(2);
    reset = 1'b0;
    event_ready = 1'b1;
    tick(10);
    chk("t6_no_stale", int'(event_valid), 0);

    // Button already high at reset release gives one PRESS
    reset = 1'b1;
    btn_level[1] = 1'b1;
    tick(2);
    reset = 1'b0;
    push(2'd1, EVT_PRESS);
    tick(4);
    btn_level[1] = 1'b0;
    push(2'd1, EVT_RELEASE);
    tick(4);

`ifdef BTN_EVT_TIMESTAMP_EN
    // Timestamp captured at 0xFE and reported after the counter wraps
    event_ready = 1'b0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    repeat (254) @(posedge clk);
    #1;
    btn_level[2] = 1'b1;
    push(2'd2, EVT_PRESS);
    tick(12);
    chk("t7_valid", int'(event_valid), 1);
    chk("t7_kind", int'(event_kind), 1);
    chk("t7_ts", int'(event_ts), 254);
    event_ready = 1'b1;
    tick(2);
    btn_level[2] = 1'b0;
    push(2'd2, EVT_RELEASE);
    tick(4);
`endif

    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
